// File: rtl/morse_key_decoder.sv
// morse_key_decoder: turns the averaged touch-sensor level into Morse key events.
// A hysteresis comparator and frame-count debounce produce a clean key level.
// A small IDLE/PRESS/GAP FSM times each press and each release gap.
// Everything advances only on frames (cycles with avg_stb=1).
// Optional feature: define MORSE_STUCK_FAULT_EN to flag and discard presses
// that reach STUCK_MAX frames. Without it, fault stays 0.
module morse_key_decoder #(
    parameter int N          = 11,
    parameter int CNT_W      = 8,
    parameter int THRESH_ON  = 1200,
    parameter int THRESH_OFF = 1100,
    parameter int DEBOUNCE   = 3,
    parameter int DOT_MAX    = 40,
    parameter int LETTER_GAP = 40,
    parameter int WORD_GAP   = 120,
    parameter int STUCK_MAX  = 250
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             avg_stb,
    input  logic [N-1:0]     averaged,
    output logic             key_down,
    output logic             sym_valid,
    output logic             sym_dash,
    output logic [CNT_W-1:0] press_len,
    output logic             letter_end,
    output logic             word_end,
    output logic             fault
);

`ifdef MORSE_STUCK_FAULT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    localparam int AG_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    localparam logic [N-1:0]     ON_L     = N'(THRESH_ON);
    localparam logic [N-1:0]     OFF_L    = N'(THRESH_OFF);
    localparam logic [AG_W-1:0]  AG_LAST  = AG_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] DOT_L    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LETTER_L = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WORD_L   = CNT_W'(WORD_GAP);
    localparam logic [CNT_W-1:0] STUCK_L  = CNT_W'(STUCK_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Frame counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             level_q, level_d;
    logic [AG_W-1:0]  agree_q, agree_d;
    logic             key_q, key_d;
    logic             toggle;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] press_q, press_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] plen_q, plen_d;
    logic             dash_q, dash_d;
    logic             sv_q, sv_d;
    logic             le_q, le_d;
    logic             we_q, we_d;
    logic             fault_q, fault_d;
    logic             stuck_q, stuck_d;
    logic             rise, fall;

    // Hysteresis level and debounce: key toggles after DEBOUNCE disagreeing frames.
    always_comb begin
        level_d = level_q;
        agree_d = agree_q;
        key_d   = key_q;
        toggle  = 1'b0;
        if (avg_stb) begin
            if (averaged >= ON_L) begin
                level_d = 1'b1;
            end else if (averaged < OFF_L) begin
                level_d = 1'b0;
            end
            if (level_d == key_q) begin
                agree_d = '0;
            end else if (agree_q >= AG_LAST) begin
                agree_d = '0;
                key_d   = ~key_q;
                toggle  = 1'b1;
            end else begin
                agree_d = agree_q + AG_W'(1);
            end
        end
    end

    assign rise = toggle & ~key_q;
    assign fall = toggle & key_q;

    // Press/gap timing FSM; event outputs default to 0 so each is a one-frame pulse.
    always_comb begin
        state_d = state_q;
        press_d = press_q;
        gap_d   = gap_q;
        plen_d  = plen_q;
        dash_d  = dash_q;
        stuck_d = stuck_q;
        sv_d    = 1'b0;
        le_d    = 1'b0;
        we_d    = 1'b0;
        fault_d = 1'b0;
        if (avg_stb) begin
            case (state_q)
                S_PRESS: begin
                    if (fall) begin
                        if (STUCK_EN && stuck_q) begin
                            // Stuck press is dropped entirely: no symbol, no gap timing.
                            state_d = S_IDLE;
                            gap_d   = '0;
                            stuck_d = 1'b0;
                        end else begin
                            state_d = S_GAP;
                            plen_d  = press_q;
                            dash_d  = (press_q > DOT_L);
                            sv_d    = 1'b1;
                            gap_d   = CNT_W'(1);
                        end
                    end else begin
                        press_d = sat_inc(press_q);
                        if (STUCK_EN && !stuck_q && press_d == STUCK_L) begin
                            fault_d = 1'b1;
                            stuck_d = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (rise) begin
                        state_d = S_PRESS;
                        press_d = CNT_W'(1);
                        gap_d   = '0;
                    end else begin
                        gap_d = sat_inc(gap_q);
                        le_d  = (gap_d == LETTER_L);
                        if (gap_d == WORD_L) begin
                            we_d    = 1'b1;
                            state_d = S_IDLE;
                            gap_d   = '0;
                        end
                    end
                end
                default: begin
                    if (rise) begin
                        state_d = S_PRESS;
                        press_d = CNT_W'(1);
                        gap_d   = '0;
                        stuck_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // State and output registers; reset drops any pending press or gap.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            agree_q <= '0;
            key_q   <= 1'b0;
            state_q <= S_IDLE;
            press_q <= '0;
            gap_q   <= '0;
            plen_q  <= '0;
            dash_q  <= 1'b0;
            sv_q    <= 1'b0;
            le_q    <= 1'b0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            level_q <= level_d;
            agree_q <= agree_d;
            key_q   <= key_d;
            state_q <= state_d;
            press_q <= press_d;
            gap_q   <= gap_d;
            plen_q  <= plen_d;
            dash_q  <= dash_d;
            sv_q    <= sv_d;
            le_q    <= le_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            stuck_q <= stuck_d;
        end
    end

    assign key_down   = key_q;
    assign sym_valid  = sv_q;
    assign sym_dash   = dash_q;
    assign press_len  = plen_q;
    assign letter_end = le_q;
    assign word_end   = we_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: table of per-frame vectors plus hand-written
// multi-frame sequences; pulse outputs are also counted by a monitor.
module tb_morse_key_decoder;

    logic       cclk;
    logic       rst;
    logic       avg_stb;
    logic [10:0] averaged;
    logic       key_down, sym_valid, sym_dash, letter_end, word_end, fault;
    logic [7:0] press_len;

    morse_key_decoder #(
        .N(11), .CNT_W(8), .THRESH_ON(1200), .THRESH_OFF(1100), .DEBOUNCE(2),
        .DOT_MAX(4), .LETTER_GAP(6), .WORD_GAP(12), .STUCK_MAX(20)
    ) dut (
        .cclk(cclk), .rst(rst), .avg_stb(avg_stb), .averaged(averaged),
        .key_down(key_down), .sym_valid(sym_valid), .sym_dash(sym_dash),
        .press_len(press_len), .letter_end(letter_end), .word_end(word_end),
        .fault(fault)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    int n_checks = 0;
    int n_err    = 0;

    // pulse counters (monitor) and snapshots
    int c_sv = 0, c_le = 0, c_we = 0, c_f = 0;
    int b_sv, b_le, b_we, b_f;

    always @(negedge cclk) begin
        if (!rst) begin
            c_sv <= c_sv + int'(sym_valid);
            c_le <= c_le + int'(letter_end);
            c_we <= c_we + int'(word_end);
            c_f  <= c_f + int'(fault);
        end
    end

    logic [31:0] s_out;
    logic        s_kd, s_fault;

    typedef struct {
        int   lvl;
        logic kd, sv, dash;
        int   plen;
        logic le, we;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] pack(input logic kd, input logic sv, input logic dash,
                                         input int plen, input logic le, input logic we,
                                         input logic f);
        logic [7:0] p;
        p = plen[7:0];
        return {18'd0, kd, sv, dash, p, le, we, f};
    endfunction

    function automatic logic [31:0] live();
        return pack(key_down, sym_valid, sym_dash, int'(press_len), letter_end, word_end, fault);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One frame: strobe for one cycle, sample registered outputs half a cycle later.
    task automatic frame(input int lvl);
        @(negedge cclk);
        averaged = 11'(lvl);
        avg_stb  = 1'b1;
        @(negedge cclk);
        avg_stb  = 1'b0;
        s_out    = live();
        s_kd     = key_down;
        s_fault  = fault;
        #1;
    endtask

    task automatic frames(input int n, input int lvl);
        for (int k = 0; k < n; k++) frame(lvl);
    endtask

    task automatic snap();
        b_sv = c_sv; b_le = c_le; b_we = c_we; b_f = c_f;
    endtask

    task automatic add(input int n, input int lvl, input logic kd, input logic sv,
                       input logic dash, input int plen, input logic le, input logic we);
        vec_t v;
        v.lvl = lvl; v.kd = kd; v.sv = sv; v.dash = dash;
        v.plen = plen; v.le = le; v.we = we;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int t4_lvls[12] = '{1300, 1300, 1150, 1300, 1150, 1300, 1150, 1000, 1300, 1150, 1000, 1000};
    int drops;
    int fault_frame;

    initial begin
        rst = 1'b1; avg_stb = 1'b0; averaged = '0;

        // 1: strobes while in reset are ignored; key rises on 2nd frame after release
        repeat (2) @(negedge cclk);
        frames(3, 2000);
        check("rst_hold_outputs", live(), 32'd0);
        @(negedge cclk) rst = 1'b0;
        frame(2000);
        check("rel_kd_frame1", {31'd0, s_kd}, 32'd0);
        frame(2000);
        check("rel_kd_frame2", {31'd0, s_kd}, 32'd1);
        @(negedge cclk) rst = 1'b1;
        #1 check("rst_async_clear", live(), 32'd0);
        @(negedge cclk) rst = 1'b0;

        // 2: dot of 3 frames, then 3: dash of 6 frames through word end
        add(1, 1300, 0, 0, 0, 0, 0, 0);
        add(2, 1300, 1, 0, 0, 0, 0, 0);
        add(1, 1000, 1, 0, 0, 0, 0, 0);
        add(1, 1000, 0, 1, 0, 3, 0, 0);
        add(1, 1000, 0, 0, 0, 3, 0, 0);
        add(1, 1300, 0, 0, 0, 3, 0, 0);
        add(5, 1300, 1, 0, 0, 3, 0, 0);
        add(1, 1000, 1, 0, 0, 3, 0, 0);
        add(1, 1000, 0, 1, 1, 6, 0, 0);
        add(4, 1000, 0, 0, 1, 6, 0, 0);
        add(1, 1000, 0, 0, 1, 6, 1, 0);
        add(5, 1000, 0, 0, 1, 6, 0, 0);
        add(1, 1000, 0, 0, 1, 6, 0, 1);
        foreach (tbl[i]) begin
            frame(tbl[i].lvl);
            check($sformatf("vec%0d", i), s_out,
                  pack(tbl[i].kd, tbl[i].sv, tbl[i].dash, tbl[i].plen, tbl[i].le, tbl[i].we, 1'b0));
        end
        snap();
        frames(3, 1000);
        check("idle_no_events", 32'(c_sv - b_sv + c_le - b_le + c_we - b_we), 32'd0);

        // 4: hysteresis band and one-frame glitch keep the key down
        snap();
        drops = 0;
        for (int i = 0; i < 12; i++) begin
            frame(t4_lvls[i]);
            if (i >= 1 && i <= 10 && s_kd !== 1'b1) drops++;
        end
        check("hyst_key_held", 32'(drops), 32'd0);
        check("hyst_release", s_out, pack(0, 1, 1, 10, 0, 0, 0));
        frames(11, 1000);
        check("hyst_sym_count", 32'(c_sv - b_sv), 32'd1);
        check("hyst_gap_events", 32'(((c_le - b_le) << 8) | (c_we - b_we)), 32'h101);

        // 5a: dot, short gap, dot -> same letter
        snap();
        frames(2, 1300); frame(1000); frame(1000);
        check("dot_a_release", s_out, pack(0, 1, 0, 2, 0, 0, 0));
        frames(2, 1000); frames(2, 1300); frames(2, 1000);
        frames(5, 1000);
        check("short_gap_events",
              32'(((c_sv - b_sv) << 16) | ((c_le - b_le) << 8) | (c_we - b_we)), 32'h020100);
        frames(6, 1000);
        check("short_gap_word", 32'(c_we - b_we), 32'd1);

        // 5b: dot, 8-frame gap, dot -> letter end between, no word end
        snap();
        frames(2, 1300); frames(2, 1000);
        frames(6, 1000); frames(2, 1300);
        check("long_gap_mid",
              32'(((c_sv - b_sv) << 16) | ((c_le - b_le) << 8) | (c_we - b_we)), 32'h010100);
        frames(2, 1000); frames(5, 1000);
        check("long_gap_after",
              32'(((c_sv - b_sv) << 16) | ((c_le - b_le) << 8) | (c_we - b_we)), 32'h020200);
        frames(6, 1000);

        // 6: 25-frame press
        snap();
        fault_frame = -1;
        for (int i = 1; i <= 25; i++) begin
            frame(1300);
            if (s_fault === 1'b1) fault_frame = i;
        end
`ifdef MORSE_STUCK_FAULT_EN
        check("stuck_fault_frame", 32'(fault_frame), 32'd21);
        frames(2, 1000);
        check("stuck_no_symbol", 32'(((c_sv - b_sv) << 8) | (c_f - b_f)), 32'h001);
        frames(12, 1000);
        check("stuck_no_gap_events", 32'(c_le - b_le + c_we - b_we), 32'd0);
`else
        check("no_fault_long_press", 32'(fault_frame), 32'hFFFF_FFFF);
        frames(2, 1000);
        check("long_press_dash", s_out, pack(0, 1, 1, 25, 0, 0, 0));
        frames(11, 1000);
        check("long_press_word", 32'(((c_we - b_we) << 8) | (c_f - b_f)), 32'h100);
`endif

        // reset in the middle of a press
        frames(5, 1300);
        check("midpress_kd", {31'd0, s_kd}, 32'd1);
        @(negedge cclk) rst = 1'b1;
        #1 check("midpress_rst_clear", live(), 32'd0);
        repeat (2) @(negedge cclk);
        rst = 1'b0;
        snap();
        frames(3, 1000);
        check("midpress_dropped", 32'((c_sv - b_sv) << 1 | int'(s_kd)), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
